pll_ctrl_seq: RTL

//  Power-up and rate-change sequencer for the TX PHY PLL block. Holds the PLL and both clock

---
 rtl/pll_ctrl_pkg.sv | 30 +++
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_ctrl_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding, rate type and divider ratio table for the TX PHY PLL sequencer.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        StRstHold,
        StWaitLock,
        StSettle,
        StReady,
        StRateChg
    } pll_state_e;

    typedef enum logic {
        RateGen1 = 1'b0,
        RateGen2 = 1'b1
    } rate_t;

    localparam logic [7:0] Gen1SymRatio  = 8'd20;
    localparam logic [7:0] Gen1PclkRatio = 8'd40;
    localparam logic [7:0] Gen2SymRatio  = 8'd10;
    localparam logic [7:0] Gen2PclkRatio = 8'd20;

    function automatic logic [7:0] sym_ratio(input rate_t rate);
        return (rate == RateGen2) ? Gen2SymRatio : Gen1SymRatio;
    endfunction

    function automatic logic [7:0] pclk_ratio(input rate_t rate);
        return (rate == RateGen2) ? Gen2PclkRatio : Gen1PclkRatio;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with asynchronous active-low reset to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/pll_ctrl_seq.sv
// PLL power-up / PIPE rate-change sequencer; all outputs registered.
// Optional lock timeout with retries and sticky Lock_Err: define PLL_LOCK_TIMEOUT_EN.
module pll_ctrl_seq
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYC = 16,
    parameter int unsigned SETTLE_CYC   = 64,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned CNT_W        = 12
) (
    input  logic       Ref_Clk,
    input  logic       Rst,
    input  logic       Rate,
    input  logic       Pll_Lock,
    output logic       Pll_Rst_n,
    output logic [7:0] Sym_Div_Ratio,
    output logic [7:0] Pclk_Div_Ratio,
    output logic       Clk_Stable,
    output logic       PhyStatus,
    output logic       Rate_Ack,
    output logic       Lock_Err
);

    localparam int unsigned CntMax = (1 << CNT_W) - 1;

    if (RST_HOLD_CYC == 0 || SETTLE_CYC == 0 || LOCK_TIMEOUT == 0 || MAX_RETRY > 255 ||
        RST_HOLD_CYC - 1 > CntMax || SETTLE_CYC - 1 > CntMax ||
        LOCK_TIMEOUT - 1 > CntMax) begin : gen_bad_param
        $error("pll_ctrl_seq: parameter out of range");
    end

    localparam logic [CNT_W-1:0] HoldLoad   = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] LockLoad   = CNT_W'(LOCK_TIMEOUT - 1);

    pll_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    rate_t            rate_q;
    logic             lock_sync;

    sync_2ff u_lock_sync (
        .clk_i  (Ref_Clk),
        .rst_ni (Rst),
        .d_i    (Pll_Lock),
        .q_o    (lock_sync)
    );

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam int unsigned RetryW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RetryW-1:0] retry_q;
`else
    assign Lock_Err = 1'b0;
`endif

    always_ff @(posedge Ref_Clk or negedge Rst) begin
        if (!Rst) begin
            state_q        <= StRstHold;
            cnt_q          <= HoldLoad;
            rate_q         <= RateGen1;
            Pll_Rst_n      <= 1'b0;
            Sym_Div_Ratio  <= Gen1SymRatio;
            Pclk_Div_Ratio <= Gen1PclkRatio;
            Clk_Stable     <= 1'b0;
            PhyStatus      <= 1'b0;
            Rate_Ack       <= 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
            retry_q        <= '0;
            Lock_Err       <= 1'b0;
`endif
        end else begin
            PhyStatus <= 1'b0;
            unique case (state_q)
                StRstHold: begin
                    if (cnt_q == '0) begin
                        state_q   <= StWaitLock;
                        cnt_q     <= LockLoad;
                        Pll_Rst_n <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StWaitLock: begin
                    if (lock_sync) begin
                        state_q <= StSettle;
                        cnt_q   <= SettleLoad;
                    end
`ifdef PLL_LOCK_TIMEOUT_EN
                    // Once Lock_Err is set the FSM parks here and only a real lock moves it on.
                    else if (!Lock_Err) begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end else if (retry_q == RetryW'(MAX_RETRY)) begin
                            Lock_Err <= 1'b1;
                        end else begin
                            retry_q   <= retry_q + RetryW'(1);
                            state_q   <= StRstHold;
                            cnt_q     <= HoldLoad;
                            Pll_Rst_n <= 1'b0;
                        end
                    end
`endif
                end
                StSettle: begin
                    if (!lock_sync) begin
                        state_q <= StWaitLock;
                        cnt_q   <= LockLoad;
                    end else if (cnt_q == '0) begin
                        state_q    <= StReady;
                        Clk_Stable <= 1'b1;
                        PhyStatus  <= 1'b1;
                        Rate_Ack   <= rate_q;
`ifdef PLL_LOCK_TIMEOUT_EN
                        retry_q    <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StReady: begin
                    // Lock loss takes priority and picks up whatever Rate is requested now.
                    if (!lock_sync) begin
                        state_q        <= StRstHold;
                        cnt_q          <= HoldLoad;
                        Pll_Rst_n      <= 1'b0;
                        Clk_Stable     <= 1'b0;
                        rate_q         <= rate_t'(Rate);
                        Sym_Div_Ratio  <= sym_ratio(rate_t'(Rate));
                        Pclk_Div_Ratio <= pclk_ratio(rate_t'(Rate));
                    end else if (Rate != Rate_Ack) begin
                        state_q    <= StRateChg;
                        Clk_Stable <= 1'b0;
                    end
                end
                StRateChg: begin
                    state_q        <= StRstHold;
                    cnt_q          <= HoldLoad;
                    Pll_Rst_n      <= 1'b0;
                    rate_q         <= rate_t'(Rate);
                    Sym_Div_Ratio  <= sym_ratio(rate_t'(Rate));
                    Pclk_Div_Ratio <= pclk_ratio(rate_t'(Rate));
                end
                default: begin
                    state_q   <= StRstHold;
                    cnt_q     <= HoldLoad;
                    Pll_Rst_n <= 1'b0;
                end
            endcase
        end
    end

endmodule
